// File: rtl/zx_raster_timing.sv
// Raster counters, screen-fetch scheduler, blank/sync, CPU INT and FLASH phase for the video path.
// Latency: counts, strobes, SCREEN_ADDR, SCREEN_SHOW combinational; BLANK/syncs/INT_N/FRAME_START one tick late.
// Backpressure: none; free-running on CLK_14MHZ, MODE is adopted only at frame wrap or during RESET.
module zx_raster_timing #(
  parameter int H_AREA        = 256,
  parameter int V_AREA        = 192,
  parameter int INT_LEN       = 64,
  parameter int INT_HPOS      = 320,
  parameter int INT_LINE_PENT = 239,
  parameter int INT_LINE_48   = 248,
  parameter int INT_LINE_128  = 248,
  // Frame geometry per mode, in pixels and lines
  parameter int H_TOT_PENT    = 448,
  parameter int V_TOT_PENT    = 320,
  parameter int H_TOT_48      = 448,
  parameter int V_TOT_48      = 312,
  parameter int H_TOT_128     = 456,
  parameter int V_TOT_128     = 311,
  // Blank and sync windows, common to all modes (begin inclusive, end exclusive)
  parameter int HBLANK_BEG    = 320,
  parameter int HBLANK_END    = 416,
  parameter int HSYNC_BEG     = 328,
  parameter int HSYNC_END     = 360,
  parameter int VBLANK_BEG    = 240,
  parameter int VSYNC_BEG     = 248,
  parameter int VBLANK_END    = 256
) (
  input  logic        CLK_14MHZ,
  input  logic        RESET,
  input  logic [1:0]  MODE,
  output logic [1:0]  MODE_ACT,
  output logic [8:0]  HC,
  output logic [8:0]  VC,
  output logic        PIX_EN,
  output logic        FETCH_BMP,
  output logic        FETCH_ATTR,
  output logic        LOAD,
  output logic [12:0] SCREEN_ADDR,
  output logic        SCREEN_SHOW,
  output logic        BLANK,
  output logic        HSYNC_N,
  output logic        VSYNC_N,
  output logic        CSYNC_N,
  output logic        INT_N,
  output logic        BLINK,
  output logic        FRAME_START
);

  localparam int INT_TICKS = 2 * INT_LEN;
  localparam int ICW       = $clog2(INT_TICKS + 1);

  localparam logic [9:0] H_LAST_PENT = 10'(2 * H_TOT_PENT - 1);
  localparam logic [9:0] H_LAST_48   = 10'(2 * H_TOT_48 - 1);
  localparam logic [9:0] H_LAST_128  = 10'(2 * H_TOT_128 - 1);
  localparam logic [8:0] V_LAST_PENT = 9'(V_TOT_PENT - 1);
  localparam logic [8:0] V_LAST_48   = 9'(V_TOT_48 - 1);
  localparam logic [8:0] V_LAST_128  = 9'(V_TOT_128 - 1);
  localparam logic [8:0] INT_LN_PENT = 9'(INT_LINE_PENT);
  localparam logic [8:0] INT_LN_48   = 9'(INT_LINE_48);
  localparam logic [8:0] INT_LN_128  = 9'(INT_LINE_128);
  localparam logic [9:0] INT_HC0     = 10'(2 * INT_HPOS);

  localparam logic [8:0] H_AREA_C     = 9'(H_AREA);
  localparam logic [8:0] V_AREA_C     = 9'(V_AREA);
  localparam logic [8:0] SHOW_END_C   = 9'(H_AREA + 8);
  localparam logic [8:0] HBLANK_BEG_C = 9'(HBLANK_BEG);
  localparam logic [8:0] HBLANK_END_C = 9'(HBLANK_END);
  localparam logic [8:0] HSYNC_BEG_C  = 9'(HSYNC_BEG);
  localparam logic [8:0] HSYNC_END_C  = 9'(HSYNC_END);
  localparam logic [8:0] VBLANK_BEG_C = 9'(VBLANK_BEG);
  localparam logic [8:0] VSYNC_BEG_C  = 9'(VSYNC_BEG);
  localparam logic [8:0] VBLANK_END_C = 9'(VBLANK_END);

  localparam logic [ICW-1:0] INT_RELOAD = ICW'(INT_TICKS - 1);

  logic [9:0]     hc0;
  logic [8:0]     vc;
  logic [1:0]     mode_act;
  logic [1:0]     mode_req;
  logic [9:0]     h_last;
  logic [8:0]     v_last;
  logic [8:0]     int_line;
  logic           h_wrap;
  logic           frame_wrap;
  logic           int_match;
  logic           fetch_win;
  logic           vis_line;
  logic [12:0]    bmp_addr;
  logic [12:0]    attr_addr;
  logic           blank_d;
  logic           hsync_d;
  logic           vsync_d;
  logic [ICW-1:0] int_cnt;
  logic [4:0]     blink_cnt;
  logic           int_n_q;
  logic           blank_q;
  logic           hsync_n_q;
  logic           vsync_n_q;
  logic           csync_n_q;
  logic           frame_start_q;

  // Mode 3 is an alias of Pentagon, so it is folded before it is ever held
  assign mode_req = (MODE == 2'd3) ? 2'd0 : MODE;

  // Terminal counts and INT line of the geometry in force
  always_comb begin
    h_last   = H_LAST_PENT;
    v_last   = V_LAST_PENT;
    int_line = INT_LN_PENT;
    case (mode_act)
      2'd1: begin
        h_last   = H_LAST_48;
        v_last   = V_LAST_48;
        int_line = INT_LN_48;
      end
      2'd2: begin
        h_last   = H_LAST_128;
        v_last   = V_LAST_128;
        int_line = INT_LN_128;
      end
      default: begin
      end
    endcase
  end

  assign h_wrap     = (hc0 == h_last);
  assign frame_wrap = h_wrap && (vc == v_last);

  // Tick/line counters; geometry changes only between frames so a frame is never torn
  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      hc0      <= '0;
      vc       <= '0;
      mode_act <= mode_req;
    end else if (h_wrap) begin
      hc0 <= '0;
      if (frame_wrap) begin
        vc       <= '0;
        mode_act <= mode_req;
      end else begin
        vc <= vc + 9'd1;
      end
    end else begin
      hc0 <= hc0 + 10'd1;
    end
  end

  assign MODE_ACT = mode_act;
  assign HC       = hc0[9:1];
  assign VC       = vc;
  assign PIX_EN   = hc0[0];

  // Fetch slots sit at the end of each 16-tick cell: bitmap, attribute, then shifter load
  assign fetch_win  = (vc < V_AREA_C) && (HC < H_AREA_C);
  assign FETCH_BMP  = fetch_win && (hc0[3:0] == 4'd12);
  assign FETCH_ATTR = fetch_win && (hc0[3:0] == 4'd14);
  assign LOAD       = fetch_win && (hc0[3:0] == 4'd15);

  // Spectrum bitmap interleave: third, pixel row in char, char row, column
  assign bmp_addr    = {vc[7:6], vc[2:0], vc[5:3], HC[7:3]};
  assign attr_addr   = {3'b110, vc[7:3], HC[7:3]};
  assign SCREEN_ADDR = FETCH_BMP ? bmp_addr : attr_addr;

  // Shown area trails the fetch window by one cell, the shifter's load delay
  assign vis_line    = (vc < V_AREA_C);
  assign SCREEN_SHOW = vis_line && (HC >= 9'd8) && (HC < SHOW_END_C);

  assign blank_d   = ((HC >= HBLANK_BEG_C) && (HC < HBLANK_END_C)) ||
                     ((vc >= VBLANK_BEG_C) && (vc < VBLANK_END_C));
  assign hsync_d   = (HC >= HSYNC_BEG_C) && (HC < HSYNC_END_C);
  assign vsync_d   = (vc >= VSYNC_BEG_C) && (vc < VBLANK_END_C);
  assign int_match = (vc == int_line) && (hc0 == INT_HC0);

  // Registered blank, syncs and frame marker, one tick behind the count
  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      blank_q       <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      csync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      hsync_n_q     <= ~hsync_d;
      vsync_n_q     <= ~vsync_d;
      csync_n_q     <= ~(hsync_d ^ vsync_d);
      frame_start_q <= frame_wrap;
    end
  end

  // INT pulse timer and FLASH counter; a match while INT_N is low is ignored
  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      int_n_q   <= 1'b1;
      int_cnt   <= '0;
      blink_cnt <= '0;
    end else if (int_match && int_n_q) begin
      int_n_q   <= 1'b0;
      int_cnt   <= INT_RELOAD;
      blink_cnt <= blink_cnt + 5'd1;
    end else if (int_cnt != '0) begin
      int_cnt <= int_cnt - ICW'(1);
    end else begin
      int_n_q <= 1'b1;
    end
  end

  assign BLANK       = blank_q;
  assign HSYNC_N     = hsync_n_q;
  assign VSYNC_N     = vsync_n_q;
  assign CSYNC_N     = csync_n_q;
  assign INT_N       = int_n_q;
  assign BLINK       = blink_cnt[4];
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_zx_raster_timing.sv
// Bench for zx_raster_timing, run on a shrunken geometry so whole frames fit the cycle budget.
// Latency: every tick is compared 1 time unit after the clock edge against a frame-position model.
// Backpressure: none; MODE and RESET are driven directly, including random changes.
module tb_zx_raster_timing;

  localparam int H_AREA = 16, V_AREA = 16, INT_LEN = 8, INT_HPOS = 28;
  localparam int INT_LINE_PENT = 17, INT_LINE_48 = 19, INT_LINE_128 = 20;
  localparam int H_TOT_PENT = 30, V_TOT_PENT = 24;
  localparam int H_TOT_48 = 30, V_TOT_48 = 23;
  localparam int H_TOT_128 = 32, V_TOT_128 = 22;
  localparam int HBLANK_BEG = 18, HBLANK_END = 26, HSYNC_BEG = 20, HSYNC_END = 24;
  localparam int VBLANK_BEG = 18, VSYNC_BEG = 20, VBLANK_END = 22;
  localparam int INT_TICKS = 2 * INT_LEN;

  logic        CLK_14MHZ = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  MODE = 2'd0;
  logic [1:0]  MODE_ACT;
  logic [8:0]  HC, VC;
  logic        PIX_EN, FETCH_BMP, FETCH_ATTR, LOAD;
  logic [12:0] SCREEN_ADDR;
  logic        SCREEN_SHOW, BLANK, HSYNC_N, VSYNC_N, CSYNC_N, INT_N, BLINK, FRAME_START;

  always #5 CLK_14MHZ = ~CLK_14MHZ;

  zx_raster_timing #(
    .H_AREA(H_AREA), .V_AREA(V_AREA), .INT_LEN(INT_LEN), .INT_HPOS(INT_HPOS),
    .INT_LINE_PENT(INT_LINE_PENT), .INT_LINE_48(INT_LINE_48), .INT_LINE_128(INT_LINE_128),
    .H_TOT_PENT(H_TOT_PENT), .V_TOT_PENT(V_TOT_PENT), .H_TOT_48(H_TOT_48), .V_TOT_48(V_TOT_48),
    .H_TOT_128(H_TOT_128), .V_TOT_128(V_TOT_128),
    .HBLANK_BEG(HBLANK_BEG), .HBLANK_END(HBLANK_END), .HSYNC_BEG(HSYNC_BEG), .HSYNC_END(HSYNC_END),
    .VBLANK_BEG(VBLANK_BEG), .VSYNC_BEG(VSYNC_BEG), .VBLANK_END(VBLANK_END)
  ) dut (
    .CLK_14MHZ(CLK_14MHZ), .RESET(RESET), .MODE(MODE), .MODE_ACT(MODE_ACT),
    .HC(HC), .VC(VC), .PIX_EN(PIX_EN), .FETCH_BMP(FETCH_BMP), .FETCH_ATTR(FETCH_ATTR),
    .LOAD(LOAD), .SCREEN_ADDR(SCREEN_ADDR), .SCREEN_SHOW(SCREEN_SHOW), .BLANK(BLANK),
    .HSYNC_N(HSYNC_N), .VSYNC_N(VSYNC_N), .CSYNC_N(CSYNC_N), .INT_N(INT_N),
    .BLINK(BLINK), .FRAME_START(FRAME_START)
  );

  typedef struct packed {
    logic [1:0]  mode_act;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic        pix_en, fbmp, fattr, load;
    logic [12:0] addr;
    logic        show, blank, hs_n, vs_n, cs_n, int_n, blink, fs;
  } obs_t;

  typedef struct {
    int          vc;
    int          hc0;
    logic        bmp, attr, load, show;
    logic [12:0] addr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: linear tick index inside the frame, absolute tick count, INT start instant
  bit m_valid = 0;
  int m_cur = 0;
  int m_ft = 0;
  int m_mode = 0;
  bit m_has_s = 0;
  int m_s = 0;
  int m_starts = 0;
  bit m_blank = 0, m_hs_n = 1, m_vs_n = 1, m_cs_n = 1, m_fs = 0;

  function automatic int norm_mode(input logic [1:0] md);
    return (md == 2'd3) ? 0 : int'(md);
  endfunction

  function automatic int h_tot(input int md);
    case (md)
      1: return H_TOT_48;
      2: return H_TOT_128;
      default: return H_TOT_PENT;
    endcase
  endfunction

  function automatic int v_tot(input int md);
    case (md)
      1: return V_TOT_48;
      2: return V_TOT_128;
      default: return V_TOT_PENT;
    endcase
  endfunction

  function automatic int int_line(input int md);
    case (md)
      1: return INT_LINE_48;
      2: return INT_LINE_128;
      default: return INT_LINE_PENT;
    endcase
  endfunction

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic bit int_low(input int t);
    return m_has_s && (t > m_s) && (t <= m_s + INT_TICKS);
  endfunction

  task automatic model_edge(input logic rst, input logic [1:0] md);
    int line, flen, x, y, hcol;
    bit hs, vs;
    line = 2 * h_tot(m_mode);
    flen = line * v_tot(m_mode);
    x = m_ft % line;
    y = m_ft / line;
    hcol = x / 2;
    if (rst) begin
      m_valid = 1; m_ft = 0; m_mode = norm_mode(md); m_has_s = 0; m_starts = 0;
      m_blank = 0; m_hs_n = 1; m_vs_n = 1; m_cs_n = 1; m_fs = 0;
    end else begin
      hs = in_range(hcol, HSYNC_BEG, HSYNC_END);
      vs = in_range(y, VSYNC_BEG, VBLANK_END);
      m_blank = in_range(hcol, HBLANK_BEG, HBLANK_END) || in_range(y, VBLANK_BEG, VBLANK_END);
      m_hs_n = !hs;
      m_vs_n = !vs;
      m_cs_n = (hs == vs);
      if (y == int_line(m_mode) && x == 2 * INT_HPOS && !int_low(m_cur)) begin
        m_has_s = 1; m_s = m_cur; m_starts++;
      end
      m_fs = (m_ft == flen - 1);
      m_ft++;
      if (m_ft == flen) begin
        m_ft = 0;
        m_mode = norm_mode(md);
      end
    end
    m_cur++;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int line, x, y, hcol, col, bmp, attr;
    bit win;
    line = 2 * h_tot(m_mode);
    x = m_ft % line;
    y = m_ft / line;
    hcol = x / 2;
    col = (hcol / 8) % 32;
    win = (y < V_AREA) && (hcol < H_AREA);
    bmp = ((y / 64) % 4) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + col;
    attr = 6144 + ((y / 8) % 32) * 32 + col;
    o.mode_act = 2'(m_mode);
    o.hc = 9'(hcol);
    o.vc = 9'(y);
    o.pix_en = (x % 2) == 1;
    o.fbmp = win && (x % 16) == 12;
    o.fattr = win && (x % 16) == 14;
    o.load = win && (x % 16) == 15;
    o.addr = 13'(o.fbmp ? bmp : attr);
    o.show = (y < V_AREA) && (hcol >= 8) && (hcol < H_AREA + 8);
    o.blank = m_blank;
    o.hs_n = m_hs_n;
    o.vs_n = m_vs_n;
    o.cs_n = m_cs_n;
    o.int_n = !int_low(m_cur);
    o.blink = ((m_starts / 16) % 2) == 1;
    o.fs = m_fs;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.mode_act = MODE_ACT; o.hc = HC; o.vc = VC; o.pix_en = PIX_EN;
    o.fbmp = FETCH_BMP; o.fattr = FETCH_ATTR; o.load = LOAD; o.addr = SCREEN_ADDR;
    o.show = SCREEN_SHOW; o.blank = BLANK; o.hs_n = HSYNC_N; o.vs_n = VSYNC_N;
    o.cs_n = CSYNC_N; o.int_n = INT_N; o.blink = BLINK; o.fs = FRAME_START;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    obs_t a, e;
    @(posedge CLK_14MHZ);
    model_edge(RESET, MODE);
    #1;
    if (m_valid) begin
      a = dut_obs();
      e = model_obs();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model t=%0d got=%h expected=%h", m_cur, a, e);
      end
    end
  endtask

  task automatic wait_fs(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (FRAME_START !== 1'b1 && n < bound);
    if (FRAME_START !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_frame_start: timeout after %0d ticks", n);
    end
  endtask

  task automatic wait_int_fall(input int bound, output int n);
    logic prev;
    n = 0;
    do begin
      prev = INT_N;
      tick();
      n++;
    end while (!(prev === 1'b1 && INT_N === 1'b0) && n < bound);
    if (INT_N !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_int: timeout after %0d ticks", n);
    end
  endtask

  initial begin
    vec_t tbl [9];
    int n, n2, g, tgt, hs_low, vs_low, vs_first, bl_cnt;

    // Fetch/show points in the first Pentagon frame (60 ticks per line), ascending in time
    tbl[0] = '{0,  15, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1800};
    tbl[1] = '{5,  28, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0501};
    tbl[2] = '{5,  30, 1'b0, 1'b1, 1'b0, 1'b1, 13'h1801};
    tbl[3] = '{5,  31, 1'b0, 1'b0, 1'b1, 1'b1, 13'h1801};
    tbl[4] = '{9,  12, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0120};
    tbl[5] = '{9,  14, 1'b0, 1'b1, 1'b0, 1'b0, 13'h1820};
    tbl[6] = '{9,  44, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1822};
    tbl[7] = '{15, 28, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0721};
    tbl[8] = '{16, 12, 1'b0, 1'b0, 1'b0, 1'b0, 13'h1840};

    RESET = 1'b1;
    MODE = 2'd0;
    repeat (3) tick();
    chk("reset_hc", HC, 0);
    chk("reset_vc", VC, 0);
    chk("reset_int_n", INT_N, 1);
    chk("reset_hsync_n", HSYNC_N, 1);
    chk("reset_blank", BLANK, 0);
    chk("reset_frame_start", FRAME_START, 0);
    chk("reset_mode_act", MODE_ACT, 0);
    RESET = 1'b0;

    for (int i = 0; i < 9; i++) begin
      tgt = tbl[i].vc * 2 * H_TOT_PENT + tbl[i].hc0;
      g = 0;
      while (m_ft != tgt && g < 3000) begin
        tick();
        g++;
      end
      chk($sformatf("tbl%0d_reached", i), m_ft, tgt);
      chk($sformatf("tbl%0d_bmp", i), FETCH_BMP, tbl[i].bmp);
      chk($sformatf("tbl%0d_attr", i), FETCH_ATTR, tbl[i].attr);
      chk($sformatf("tbl%0d_load", i), LOAD, tbl[i].load);
      chk($sformatf("tbl%0d_show", i), SCREEN_SHOW, tbl[i].show);
      chk($sformatf("tbl%0d_addr", i), SCREEN_ADDR, tbl[i].addr);
    end

    // Pentagon frame period, INT position and pulse width (pulse straddles a line wrap)
    wait_fs(3000, n);
    wait_fs(3000, n);
    chk("pent_frame_period", n, 2 * H_TOT_PENT * V_TOT_PENT);
    wait_int_fall(3000, n);
    chk("pent_int_offset", n, INT_LINE_PENT * 2 * H_TOT_PENT + 2 * INT_HPOS + 1);
    n = 0;
    while (INT_N === 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("pent_int_width", n, INT_TICKS);

    // Mid-frame switch to 128K takes effect only at the next wrap
    wait_fs(3000, n);
    repeat (300) tick();
    MODE = 2'd2;
    tick();
    chk("mode_hold_midframe", MODE_ACT, 0);
    wait_fs(3000, n);
    chk("mode_128_at_wrap", MODE_ACT, 2);
    wait_int_fall(3000, n);
    chk("m128_int_offset", n, INT_LINE_128 * 2 * H_TOT_128 + 2 * INT_HPOS + 1);
    wait_fs(3000, n2);
    chk("m128_frame_period", n + n2, 2 * H_TOT_128 * V_TOT_128);

    // 48K sync and blank coverage over one full frame
    MODE = 2'd1;
    wait_fs(3000, n);
    chk("mode_48_at_wrap", MODE_ACT, 1);
    hs_low = 0; vs_low = 0; vs_first = -1; bl_cnt = 0;
    for (int i = 1; i <= 2 * H_TOT_48 * V_TOT_48; i++) begin
      tick();
      if (HSYNC_N === 1'b0) hs_low++;
      if (VSYNC_N === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
      if (BLANK === 1'b1) bl_cnt++;
    end
    chk("m48_hsync_low_ticks", hs_low, V_TOT_48 * 2 * (HSYNC_END - HSYNC_BEG));
    chk("m48_vsync_low_ticks", vs_low, (VBLANK_END - VSYNC_BEG) * 2 * H_TOT_48);
    chk("m48_vsync_first", vs_first, VSYNC_BEG * 2 * H_TOT_48 + 1);
    chk("m48_blank_ticks", bl_cnt, 544);

    // Reset ten ticks into an INT pulse
    MODE = 2'd0;
    wait_fs(3000, n);
    wait_int_fall(3000, n);
    repeat (9) tick();
    chk("int_low_before_reset", INT_N, 0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("int_release_on_reset", INT_N, 1);
    chk("hc_after_reset", HC, 0);
    chk("vc_after_reset", VC, 0);
    wait_int_fall(3000, n);
    chk("int_after_reset", n, INT_LINE_PENT * 2 * H_TOT_PENT + 2 * INT_HPOS + 1);

    // FLASH phase over 32 INTs from reset
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      wait_int_fall(3000, n);
      if (k == 15) chk("blink_int15", BLINK, 0);
      if (k == 16) chk("blink_int16", BLINK, 1);
      if (k == 31) chk("blink_int31", BLINK, 1);
      if (k == 32) chk("blink_int32", BLINK, 0);
    end

    // Random mode changes and occasional resets, checked by the model every tick
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 399) == 0) MODE = 2'($urandom_range(0, 3));
      RESET = ($urandom_range(0, 2999) == 0);
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
